// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared mode encodings, default sizes and channel-select width helper.
package multi_timer_pkg;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_NUM_CH = 4;
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: config, control and status bundle of the multi-channel timer.
interface multi_timer_if
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CH_W = ch_width(NUM_CH)
);
    logic cfg_we;
    logic [CH_W-1:0] cfg_ch;
    logic [WIDTH-1:0] cfg_period;
    logic cfg_periodic;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
    logic [NUM_CH-1:0] irq_ack;
    logic [NUM_CH-1:0] timeout_pulse;
    logic [NUM_CH-1:0] irq_pending;
    logic [NUM_CH-1:0] running;
    logic irq;
    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_periodic, start, stop, irq_ack,
        input timeout_pulse, irq_pending, running, irq
    );
    modport slave (
        input cfg_we, cfg_ch, cfg_period, cfg_periodic, start, stop, irq_ack,
        output timeout_pulse, irq_pending, running, irq
    );
endinterface

// File: rtl/multi_timer_channel.sv
// timer_channel: one timer with shadow/active period and mode, counter, sticky pending flag.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_ack,
    output logic             timeout_pulse,
    output logic             pending,
    output logic             running
);
    logic [WIDTH-1:0] period_cfg, period_act, count, period_nxt;
    logic mode_cfg, mode_act, mode_nxt, load, expire;
    // Shadow values are seen write-through so a same-cycle write feeds start and reload.
    always_comb begin
        period_nxt = cfg_we ? cfg_period : period_cfg;
        mode_nxt = cfg_we ? cfg_periodic : mode_cfg;
        load = start && !stop && period_nxt != '0;
        expire = running && tick && !stop && !load && count == period_act - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period_cfg <= '0;
            period_act <= '0;
            mode_cfg <= MODE_ONESHOT;
            mode_act <= MODE_ONESHOT;
            count <= '0;
            running <= 1'b0;
            pending <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            period_cfg <= period_nxt;
            mode_cfg <= mode_nxt;
            timeout_pulse <= expire;
            pending <= expire || (pending && !irq_ack);
            if (stop) begin
                running <= 1'b0;
            end else if (load) begin
                period_act <= period_nxt;
                mode_act <= mode_nxt;
                count <= '0;
                running <= 1'b1;
            end else if (expire) begin
                count <= '0;
                running <= mode_act == MODE_PERIODIC;
                if (mode_act == MODE_PERIODIC && period_nxt != '0) begin
                    period_act <= period_nxt;
                    mode_act <= mode_nxt;
                end
            end else if (running && tick) begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent one-shot/periodic timers with sticky irq flags.
// Optional shared tick prescaler enabled by MULTI_TIMER_PRESCALER_EN.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CH_W = ch_width(NUM_CH),
    parameter int PRESCALE = 100
) (
    input logic clk,
    input logic reset_n,
    multi_timer_if.slave bus
);
    logic tick;
    logic [NUM_CH-1:0] pulse, pend, run;
    if (NUM_CH < 1 || NUM_CH > 16 || WIDTH < 1 || PRESCALE < 1) begin : g_bad_param
        $error("multi_timer: parameter out of range");
    end
`ifdef MULTI_TIMER_PRESCALER_EN
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PRE_W-1:0] pre;
    assign tick = pre == PRE_W'(PRESCALE - 1);
    always_ff @(posedge clk) begin
        if (!reset_n) pre <= '0;
        else pre <= tick ? '0 : pre + 1'b1;
    end
`else
    assign tick = 1'b1;
`endif
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk(clk),
            .reset_n(reset_n),
            .tick(tick),
            .cfg_we(bus.cfg_we && bus.cfg_ch == CH_W'(i)),
            .cfg_period(bus.cfg_period),
            .cfg_periodic(bus.cfg_periodic),
            .start(bus.start[i]),
            .stop(bus.stop[i]),
            .irq_ack(bus.irq_ack[i]),
            .timeout_pulse(pulse[i]),
            .pending(pend[i]),
            .running(run[i])
        );
    end
    assign bus.timeout_pulse = pulse;
    assign bus.irq_pending = pend;
    assign bus.running = run;
    assign bus.irq = |pend;
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: scoreboard bench; expected pulse cycles are queued at start and popped on each pulse.
module tb_multi_timer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int ec = 0;
    int total = 0;
    int bad = 0;
    bit mon_en = 1'b1;
    int exp_q[4][$];
    multi_timer_if #(.NUM_CH(4), .WIDTH(16), .CH_W(2)) bus ();
    multi_timer #(.NUM_CH(4), .WIDTH(16), .CH_W(2), .PRESCALE(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) ec <= ec + 1;
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ec);
        end
    endtask
    // Every observed pulse must match the oldest queued expectation for its channel.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < 4; c++) begin
                if (bus.timeout_pulse[c]) begin
                    int want;
                    want = (exp_q[c].size() != 0) ? exp_q[c].pop_front() : -1;
                    check($sformatf("pulse_edge_ch%0d", c), ec, want);
                end
            end
        end
    end
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic cfg(input int ch, input int period, input bit periodic);
        bus.cfg_we = 1'b1;
        bus.cfg_ch = 2'(ch);
        bus.cfg_period = 16'(period);
        bus.cfg_periodic = periodic;
        step();
        bus.cfg_we = 1'b0;
    endtask
    task automatic start_ch(input int ch);
        bus.start[ch] = 1'b1;
        step();
        bus.start[ch] = 1'b0;
    endtask
    task automatic stop_ch(input int ch);
        bus.stop[ch] = 1'b1;
        step();
        bus.stop[ch] = 1'b0;
    endtask
    initial begin
        int e;
        bus.cfg_we = 1'b0;
        bus.cfg_ch = '0;
        bus.cfg_period = '0;
        bus.cfg_periodic = 1'b0;
        bus.start = '1;
        bus.stop = '0;
        bus.irq_ack = '0;
        step(3);
        check("rst_running", int'(bus.running), 0);
        check("rst_pending", int'(bus.irq_pending), 0);
        check("rst_pulse", int'(bus.timeout_pulse), 0);
        check("rst_irq", int'(bus.irq), 0);
        reset_n = 1'b1;
        step();
        bus.start = '0;
        check("start_zero_period", int'(bus.running), 0);
`ifdef MULTI_TIMER_PRESCALER_EN
        begin
            int lat;
            mon_en = 1'b0;
            cfg(0, 2, 0);
            e = ec + 1;
            start_ch(0);
            lat = -1;
            for (int i = 0; i < 20 && lat < 0; i++) begin
                step();
                if (bus.timeout_pulse[0]) lat = ec - e;
            end
            check("pre_pulse_seen", int'(lat >= 0), 1);
            check($sformatf("pre_latency_%0d_in_5_8", lat), int'(lat >= 5 && lat <= 8), 1);
            check("pre_running_after", int'(bus.running[0]), 0);
        end
`else
        cfg(0, 5, 0);
        exp_q[0].push_back(ec + 1 + 5);
        start_ch(0);
        check("os_running", int'(bus.running[0]), 1);
        step(6);
        check("os_pending", int'(bus.irq_pending[0]), 1);
        check("os_irq", int'(bus.irq), 1);
        check("os_running_after", int'(bus.running[0]), 0);
        bus.irq_ack[0] = 1'b1;
        step();
        bus.irq_ack[0] = 1'b0;
        check("os_irq_acked", int'(bus.irq), 0);
        cfg(1, 3, 1);
        e = ec + 1;
        exp_q[1].push_back(e + 3);
        start_ch(1);
        step(3);
        exp_q[1].push_back(e + 6);
        exp_q[1].push_back(e + 12);
        exp_q[1].push_back(e + 18);
        cfg(1, 6, 1);
        step(15);
        stop_ch(1);
        check("per_stopped", int'(bus.running[1]), 0);
        cfg(2, 10, 0);
        start_ch(2);
        check("rs_running", int'(bus.running[2]), 1);
        step(7);
        exp_q[2].push_back(ec + 1 + 10);
        start_ch(2);
        step(11);
        check("rs_done", int'(bus.running[2]), 0);
        bus.stop[2] = 1'b1;
        start_ch(2);
        bus.stop[2] = 1'b0;
        check("start_stop_same", int'(bus.running[2]), 0);
        cfg(2, 0, 0);
        start_ch(2);
        check("start_period0", int'(bus.running[2]), 0);
        cfg(3, 1, 1);
        bus.irq_ack[3] = 1'b1;
        start_ch(3);
        for (int i = 0; i < 8; i++) begin
            exp_q[3].push_back(ec + 1);
            step();
            check($sformatf("ack_collide_%0d", i), int'(bus.irq_pending[3]), 1);
        end
        bus.irq_ack[3] = 1'b0;
        stop_ch(3);
        check("ack_stop_running", int'(bus.running[3]), 0);
        check("ack_still_pending", int'(bus.irq_pending[3]), 1);
        bus.irq_ack = '1;
        step();
        bus.irq_ack = '0;
        check("ack_clear_pending", int'(bus.irq_pending), 0);
        check("ack_clear_irq", int'(bus.irq), 0);
`endif
        step(3);
        for (int c = 0; c < 4; c++) check($sformatf("missing_pulses_ch%0d", c), exp_q[c].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
